// File: rtl/calendar_display_scan.sv
// ---------------------------------------------------------------------------
// calendar_display_scan
// Scans the clock/calendar BCD digits onto an 8-digit common-anode
// seven-segment display, one digit at a time. A page button picks the time
// page (HH.MM.SS.dc) or the date page (DD.MM...Y). All digit inputs and the
// page selection are snapshotted once per frame so a carry ripple in the
// counters never tears a displayed frame.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   page_btn            : raw page button, asynchronous, active-high
//   centesimas..        : BCD digits from the time/date counters
//   an[7:0]             : digit enables, active-low, an[0] = rightmost digit
//   seg[6:0]            : segments a..g, active-low
//   dp                  : decimal point, active-low
// ---------------------------------------------------------------------------
module calendar_display_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       page_btn,
    input  logic [3:0] centesimas,
    input  logic [3:0] decimas,
    input  logic [3:0] unidadesSegundo,
    input  logic [2:0] decenasSegundo,
    input  logic [3:0] unidadesMinuto,
    input  logic [3:0] decenasMinuto,
    input  logic [3:0] unidadesHora,
    input  logic [1:0] decenasHora,
    input  logic [3:0] unidadesDia,
    input  logic [1:0] decenasDia,
    input  logic [3:0] unidadesMes,
    input  logic       decenasMes,
    input  logic [3:0] unidadesYear,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [3:0] CODE_DASH = 4'hF;

    // Standard active-low patterns; anything above 9 shows a dash.
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // ---------------------------------------------------------------- state
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic             sync1_q, sync2_q, sync_prev_q;
    logic             page_q, page_d;
    logic             frame_end_c;

    logic [3:0] snap_cent_q, snap_deci_q, snap_useg_q, snap_umin_q, snap_dmin_q;
    logic [3:0] snap_uhor_q, snap_udia_q, snap_umes_q, snap_uyear_q;
    logic [2:0] snap_dseg_q;
    logic [1:0] snap_dhor_q, snap_ddia_q;
    logic       snap_dmes_q;
    logic       snap_page_q;

    logic [7:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;

    // Divider / digit index / page toggle next-state.
    always_comb begin
        div_d       = div_q + DIV_W'(1);
        idx_d       = idx_q;
        frame_end_c = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                frame_end_c = 1'b1;
            end
        end
        // Rising edge of the synchronized button flips the page once.
        page_d = page_q ^ (sync2_q & ~sync_prev_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            idx_q       <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync_prev_q <= 1'b0;
            page_q      <= 1'b0;
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            sync1_q     <= page_btn;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            page_q      <= page_d;
        end
    end

    // Frame snapshot: everything the decoder looks at is frozen here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_cent_q  <= '0;
            snap_deci_q  <= '0;
            snap_useg_q  <= '0;
            snap_dseg_q  <= '0;
            snap_umin_q  <= '0;
            snap_dmin_q  <= '0;
            snap_uhor_q  <= '0;
            snap_dhor_q  <= '0;
            snap_udia_q  <= '0;
            snap_ddia_q  <= '0;
            snap_umes_q  <= '0;
            snap_dmes_q  <= 1'b0;
            snap_uyear_q <= '0;
            snap_page_q  <= 1'b0;
        end else if (frame_end_c) begin
            snap_cent_q  <= centesimas;
            snap_deci_q  <= decimas;
            snap_useg_q  <= unidadesSegundo;
            snap_dseg_q  <= decenasSegundo;
            snap_umin_q  <= unidadesMinuto;
            snap_dmin_q  <= decenasMinuto;
            snap_uhor_q  <= unidadesHora;
            snap_dhor_q  <= decenasHora;
            snap_udia_q  <= unidadesDia;
            snap_ddia_q  <= decenasDia;
            snap_umes_q  <= unidadesMes;
            snap_dmes_q  <= decenasMes;
            snap_uyear_q <= unidadesYear;
            snap_page_q  <= page_q;
        end
    end

    // Month stored 0..11 is shown as 01..12; out-of-range shows "--".
    logic [3:0] mon_t_c, mon_u_c;
    always_comb begin
        mon_t_c = CODE_DASH;
        mon_u_c = CODE_DASH;
        if (!snap_dmes_q) begin
            if (snap_umes_q <= 4'd8) begin
                mon_t_c = 4'd0;
                mon_u_c = snap_umes_q + 4'd1;
            end else if (snap_umes_q == 4'd9) begin
                mon_t_c = 4'd1;
                mon_u_c = 4'd0;
            end
        end else begin
            if (snap_umes_q == 4'd0) begin
                mon_t_c = 4'd1;
                mon_u_c = 4'd1;
            end else if (snap_umes_q == 4'd1) begin
                mon_t_c = 4'd1;
                mon_u_c = 4'd2;
            end
        end
    end

    // Digit select for the current index on the snapshotted page.
    logic [3:0] code_c;
    logic       blank_c;
    logic       dp_on_c;
    always_comb begin
        code_c  = 4'd0;
        blank_c = 1'b0;
        dp_on_c = 1'b0;
        if (!snap_page_q) begin
            case (idx_q)
                3'd7: code_c = {2'b00, snap_dhor_q};
                3'd6: code_c = snap_uhor_q;
                3'd5: code_c = snap_dmin_q;
                3'd4: code_c = snap_umin_q;
                3'd3: code_c = {1'b0, snap_dseg_q};
                3'd2: code_c = snap_useg_q;
                3'd1: code_c = snap_deci_q;
                default: code_c = snap_cent_q;
            endcase
            dp_on_c = (idx_q == 3'd6) || (idx_q == 3'd4) || (idx_q == 3'd2);
        end else begin
            case (idx_q)
                3'd7: code_c = {2'b00, snap_ddia_q};
                3'd6: code_c = snap_udia_q;
                3'd5: code_c = mon_t_c;
                3'd4: code_c = mon_u_c;
                3'd0: code_c = snap_uyear_q;
                default: blank_c = 1'b1;
            endcase
            dp_on_c = (idx_q == 3'd6) || (idx_q == 3'd4);
        end
    end

    // Registered display outputs, one cycle behind idx.
    always_comb begin
        an_d  = 8'(~(8'd1 << idx_q));
        seg_d = blank_c ? SEG_BLANK : seg_of(code_c);
        dp_d  = blank_c ? 1'b1 : ~dp_on_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= 8'hFF;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
